// File: rtl/ibex_if_instr_align_buf_pkg.sv
// Shared types for the IF-stage instruction buffer/realigner.
// Entry format and compressed-opcode detection helper.
package ibex_if_instr_align_buf_pkg;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } fetch_entry_t;

  localparam logic [1:0] OPC_QUAD_32B = 2'b11;

  function automatic logic is_compressed(
    input logic [15:0] half
  );
    return half[1:0] != OPC_QUAD_32B;
  endfunction

endpackage

// File: rtl/ibex_fetch_word_ring.sv
// Circular store of fetch words with error flags.
// Exposes the two oldest entries and the fill count.
module ibex_fetch_word_ring
  import ibex_if_instr_align_buf_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [31:0]  push_data_i,
  input  logic         push_err_i,
  input  logic         pop_i,
  output fetch_entry_t e0_o,
  output fetch_entry_t e1_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] rd1;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd1     = ptr_inc(rd_q);
  assign e0_o    = mem_q[rd_q];
  assign e1_o    = mem_q[rd1];
  assign count_o = cnt_q;

  // Entry storage, pointers and count; clear overrides push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= '{err: push_err_i, data: push_data_i};
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= rd1;
      end
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ibex_if_instr_align_buf.sv
// IF-stage instruction buffer: stores fetch words and presents
// one 16- or 32-bit instruction per handshake, with PC and error.
module ibex_if_instr_align_buf
  import ibex_if_instr_align_buf_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic [31:0] in_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic        out_is_compressed_o,
  output logic        out_err_o,
  output logic [31:0] out_addr_o
);

  fetch_entry_t  e0;
  fetch_entry_t  e1;
  logic [CW-1:0] count;
  logic [31:0]   addr_q;
  logic          aligned;
  logic          c_lo;
  logic          c_hi;
  logic          has1;
  logic          has2;
  logic          comp;
  logic          valid_raw;
  logic [31:0]   rdata;
  logic          err;
  logic          push;
  logic          pop;
  logic          retire;
  logic          unused_addr_bit;
  logic [15:0]   unused_e1_hi;

  assign unused_addr_bit = in_addr_i[0];
  assign unused_e1_hi    = e1.data[31:16];

  ibex_fetch_word_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .push_i      (push),
    .push_data_i (in_rdata_i),
    .push_err_i  (in_err_i),
    .pop_i       (retire),
    .e0_o        (e0),
    .e1_o        (e1),
    .count_o     (count)
  );

  assign aligned = ~addr_q[1];
  assign c_lo    = is_compressed(e0.data[15:0]);
  assign c_hi    = is_compressed(e0.data[31:16]);
  assign has1    = (count != '0);
  assign has2    = (count >= CW'(2));

  // Realign: pick the instruction half-words and its validity/error.
  always_comb begin
    comp      = 1'b0;
    valid_raw = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    unique case (1'b1)
      aligned: begin
        comp      = c_lo;
        valid_raw = has1;
        rdata     = c_lo ? {16'b0, e0.data[15:0]} : e0.data;
        err       = e0.err;
      end
      (!aligned && c_hi): begin
        comp      = 1'b1;
        valid_raw = has1;
        rdata     = {16'b0, e0.data[31:16]};
        err       = e0.err;
      end
      (!aligned && !c_hi): begin
        comp      = 1'b0;
        valid_raw = has2 | (has1 & e0.err);
        rdata     = {e1.data[15:0], e0.data[31:16]};
        err       = e0.err | (has2 & e1.err);
      end
      default: ;
    endcase
  end

  assign in_ready_o          = (count < CW'(DEPTH));
  assign out_valid_o         = valid_raw & ~clear_i;
  assign out_rdata_o         = rdata;
  assign out_is_compressed_o = comp & has1;
  assign out_err_o           = err;
  assign out_addr_o          = addr_q;

  assign push   = in_valid_i & in_ready_o & ~clear_i;
  assign pop    = out_valid_o & out_ready_i;
  assign retire = pop & ~(aligned & comp);

  // Fetch address: reload on clear, advance by instruction size on pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else if (clear_i) begin
      addr_q <= {in_addr_i[31:1], 1'b0};
    end else if (pop) begin
      addr_q <= addr_q + (comp ? 32'd2 : 32'd4);
    end
  end

endmodule

// File: tb/tb_ibex_if_instr_align_buf.sv
// Scoreboard bench for the IF instruction buffer/realigner.
// Directed vectors; a monitor checks every handshake against a queue.
module tb_ibex_if_instr_align_buf;

  localparam int DEPTH = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        comp;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] in_addr_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_rdata_i = '0;
  logic        in_err_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_rdata_o;
  logic        out_is_compressed_o;
  logic        out_err_o;
  logic [31:0] out_addr_o;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  ibex_if_instr_align_buf #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .clear_i             (clear_i),
    .in_addr_i           (in_addr_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .in_rdata_i          (in_rdata_i),
    .in_err_i            (in_err_i),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_rdata_o         (out_rdata_o),
    .out_is_compressed_o (out_is_compressed_o),
    .out_err_o           (out_err_o),
    .out_addr_o          (out_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got addr 0x%08h want none",
                 out_addr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_rdata", out_rdata_o, e.rdata);
        chk("mon_comp", 32'(out_is_compressed_o), 32'(e.comp));
        chk("mon_err", 32'(out_err_o), 32'(e.err));
        chk("mon_addr", out_addr_o, e.addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_clear(input logic [31:0] a);
    clear_i   = 1'b1;
    in_addr_i = a;
    tick();
    clear_i   = 1'b0;
  endtask

  task automatic push(input logic [31:0] w, input logic e);
    in_valid_i = 1'b1;
    in_rdata_i = w;
    in_err_i   = e;
    tick();
    in_valid_i = 1'b0;
    in_err_i   = 1'b0;
  endtask

  task automatic expect_instr(input logic [31:0] d, input logic c,
                              input logic e, input logic [31:0] a);
    exp_t x;
    x.rdata = d;
    x.comp  = c;
    x.err   = e;
    x.addr  = a;
    sb.push_back(x);
  endtask

  task automatic pop_one();
    chk("pop_valid", 32'(out_valid_o), 32'd1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_rdata", out_rdata_o, 32'h0);
    chk("rst_comp", 32'(out_is_compressed_o), 32'd0);
    chk("rst_err", 32'(out_err_o), 32'd0);
    chk("rst_addr", out_addr_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    // Aligned 32-bit
    do_clear(32'h80);
    push(32'h00000013, 1'b0);
    chk("a32_valid", 32'(out_valid_o), 32'd1);
    expect_instr(32'h00000013, 1'b0, 1'b0, 32'h80);
    pop_one();
    chk("a32_count", 32'(dut.count), 32'd0);
    chk("a32_addr", out_addr_o, 32'h84);

    // Two compressed in one word
    do_clear(32'h80);
    push(32'h45014501, 1'b0);
    expect_instr(32'h00004501, 1'b1, 1'b0, 32'h80);
    expect_instr(32'h00004501, 1'b1, 1'b0, 32'h82);
    pop_one();
    chk("cc_count1", 32'(dut.count), 32'd1);
    chk("cc_addr1", out_addr_o, 32'h82);
    pop_one();
    chk("cc_count2", 32'(dut.count), 32'd0);
    chk("cc_addr2", out_addr_o, 32'h84);

    // Unaligned 32-bit straddling two words
    do_clear(32'h82);
    push(32'h00134501, 1'b0);
    chk("u32_wait", 32'(out_valid_o), 32'd0);
    push(32'h00000093, 1'b0);
    expect_instr(32'h00930013, 1'b0, 1'b0, 32'h82);
    pop_one();
    chk("u32_count", 32'(dut.count), 32'd1);
    chk("u32_addr", out_addr_o, 32'h86);

    // Unaligned 32-bit with erroneous first word
    do_clear(32'h82);
    push(32'h00130000, 1'b1);
    chk("uerr_count", 32'(dut.count), 32'd1);
    chk("uerr_valid", 32'(out_valid_o), 32'd1);
    chk("uerr_err", 32'(out_err_o), 32'd1);
    chk("uerr_comp", 32'(out_is_compressed_o), 32'd0);
    chk("uerr_addr", out_addr_o, 32'h82);

    // Fill, then pop with a rejected push in the same cycle
    do_clear(32'h0);
    push(32'h00000013, 1'b0);
    push(32'h00000093, 1'b0);
    push(32'h00000113, 1'b0);
    chk("full_count", 32'(dut.count), 32'(DEPTH));
    chk("full_ready", 32'(in_ready_o), 32'd0);
    expect_instr(32'h00000013, 1'b0, 1'b0, 32'h0);
    in_valid_i = 1'b1;
    in_rdata_i = 32'h00000193;
    pop_one();
    in_valid_i = 1'b0;
    chk("full_pop_count", 32'(dut.count), 32'(DEPTH - 1));
    expect_instr(32'h00000093, 1'b0, 1'b0, 32'h4);
    pop_one();
    expect_instr(32'h00000113, 1'b0, 1'b0, 32'h8);
    pop_one();
    chk("full_drained", 32'(out_valid_o), 32'd0);
    chk("full_addr", out_addr_o, 32'hC);

    // Clear wins over a simultaneous push
    do_clear(32'h100);
    push(32'h00000013, 1'b0);
    push(32'h00000093, 1'b0);
    chk("clr_pre_count", 32'(dut.count), 32'd2);
    in_valid_i = 1'b1;
    in_rdata_i = 32'h00000213;
    do_clear(32'h201);
    in_valid_i = 1'b0;
    chk("clr_count", 32'(dut.count), 32'd0);
    chk("clr_valid", 32'(out_valid_o), 32'd0);
    chk("clr_addr", out_addr_o, 32'h200);

    // Address wrap on an unaligned compressed instruction
    do_clear(32'hFFFFFFFE);
    push(32'h45010000, 1'b0);
    expect_instr(32'h00004501, 1'b1, 1'b0, 32'hFFFFFFFE);
    pop_one();
    chk("wrap_addr", out_addr_o, 32'h0);
    chk("wrap_count", 32'(dut.count), 32'd0);

    // Asynchronous reset mid-operation
    push(32'h00000013, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_count", 32'(dut.count), 32'd0);
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_addr", out_addr_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ibex_if_instr_align_buf.md
# ibex_if_instr_align_buf

Instruction buffer and realigner in the IF stage, directly upstream of the ID-stage controller. It accepts aligned 32-bit fetch words (with bus-error flags) from the prefetcher, stores them in a small circular buffer, and presents one instruction per handshake: 16-bit compressed or 32-bit, aligned or straddling two words. Its outputs drive the ID stage's instruction word, fetch-error flag and PC.

## Interface
- DEPTH, 3: number of 32-bit word entries; legal range 2..8.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  flush all entries and reload the fetch address from in_addr_i.
- in_addr_i  in  32  new instruction address, sampled when clear_i=1; bit 0 ignored.
- in_valid_i  in  1  fetch word present.
- in_ready_o  out  1  buffer can accept a word.
- in_rdata_i  in  32  fetch word, always 4-byte aligned.
- in_err_i  in  1  bus error for this word.
- out_valid_o  out  1  complete instruction available.
- out_ready_i  in  1  ID stage consumes the instruction.
- out_rdata_o  out  32  instruction; compressed form zero-extended to {16'b0, c}.
- out_is_compressed_o  out  1  instruction is 16-bit.
- out_err_o  out  1  instruction overlaps an erroneous word.
- out_addr_o  out  32  PC of the presented instruction; bit 0 always 0.

## Operation
- State:
  - DEPTH entries of {err, data[31:0]};
  - rd_ptr and wr_ptr, each clog2(DEPTH) bits, wrapping at DEPTH;
  - count, clog2(DEPTH+1) bits;
  - addr_q[31:0].
- e0 is the entry at rd_ptr; e1 is the entry at rd_ptr+1 (mod DEPTH).
- Push when in_valid_i & in_ready_o & ~clear_i. Set in_ready_o = (count < DEPTH). A pop in the same cycle gives no credit.
- Aligned case (addr_q[1]=0):
  - compressed = (e0[1:0] != 2'b11);
  - valid = (count >= 1);
  - data = e0 low half (compressed, zero-extended) or all of e0 (32-bit);
  - err = e0.err.
- Unaligned case (addr_q[1]=1):
  - compressed = (e0[17:16] != 2'b11).
  - Compressed: valid = (count >= 1); data = {16'b0, e0[31:16]}; err = e0.err.
  - 32-bit: data = {e1[15:0], e0[31:16]}; valid = (count >= 2) | (count >= 1 & e0.err); err = e0.err | (count >= 2 & e1.err).
- out_valid_o is gated by ~clear_i.
- Pop on out_valid_o & out_ready_i:
  - addr_q advances by 2 (compressed) or 4 (32-bit), modulo 2^32.
  - rd_ptr/count retire one entry unless the instruction was aligned compressed; in that case no entry is retired.
  - At most one entry is retired per cycle, including the unaligned 32-bit case, where e1 becomes the new e0.
- Errored instructions are popped normally. The downstream controller flushes through clear_i.
- clear_i wins over push and pop. Next cycle: count=0, pointers=0, addr_q={in_addr_i[31:1],1'b0}. A word pushed in the clear cycle is discarded.

## Timing
- Reset values:
  - count=0, pointers=0, all entries 0, addr_q=0;
  - out_valid_o=0, in_ready_o=1, out_rdata_o=0, out_is_compressed_o=0, out_err_o=0, out_addr_o=0.
- There is no bypass. A word pushed in cycle N is presented at the earliest in cycle N+1.
- All outputs are combinational from registered state, except the out_valid_o gate on clear_i.
- Unaligned 32-bit instruction with only e0 present: out_valid_o=0 until e1 arrives, unless e0.err=1.
- Full (count=DEPTH) with simultaneous pop: in_ready_o stays 0 that cycle; count drops by 1 next cycle.
- Simultaneous push and retiring pop: count unchanged; both pointers advance.
- Wrap: pointers roll DEPTH-1 -> 0; addr_q 0xFFFFFFFE+2 -> 0x00000000 with no flag.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

## Structure
- No new shared package entries. Compressed detection uses the existing 2'b11 opcode-quadrant convention.
- One natural sub-module: ibex_fetch_word_ring. It holds the entry storage, the pointers and count, the push/pop/clear logic, and exposes e0, e1 and count.
- The top level contains the realignment and address logic.

## Test plan
- Clear to 0x80 and push 0x00000013: out_valid_o=1 next cycle; out_rdata_o=0x00000013; compressed=0; addr=0x80; pop -> count=0, addr=0x84.
- Clear to 0x80 and push 0x45014501: two compressed instructions 0x00004501 at 0x80, then at 0x82. Only the second pop retires the entry; final addr=0x84.
- Clear to 0x82; push 0x00134501, then 0x00000093: out_valid_o stays 0 after the first word and rises after the second. out_rdata_o=0x00930013; addr=0x82; after pop, count=1 and addr=0x86.
- Clear to 0x82; push 0x00130000 with in_err_i=1: out_valid_o=1 with count=1; out_err_o=1; addr=0x82.
- Push DEPTH words without popping: in_ready_o=0 at count=DEPTH. A pop and in_valid_i in the same cycle -> count=DEPTH-1 and the word is not accepted.
- clear_i to 0x200 while count=2 and in_valid_i=1: next cycle count=0, out_valid_o=0, addr=0x200; the pushed word is absent.
